umul_seq_ctrl: RTL

Sequencer for one unary (bitstream) multiply over a full window of 2^BITWIDTH cycles. Accepts operand pair A/B via valid/ready and clears two external sobolrng instances. Steps RNG A every run cycle and RNG B only on A-stream '1' cycles (uMUL temporal coding). Counts product '1's and returns the count via valid/ready. Sits between the operand source and the two RNGs in the uMUL datapath.

---
 rtl/umul_seq_ctrl_pkg.sv | 18 +
 rtl/umul_seq_ctrl_cntwithen.sv | 35 +++
 rtl/umul_seq_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/umul_seq_ctrl_pkg.sv
// Shared definitions for the unary-multiply sequencer: FSM encoding and window sizing.
package umul_seq_ctrl_pkg;

    localparam int unsigned BITWIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // One full bitstream window covers every RNG value exactly once.
    function automatic int unsigned win_len(input int unsigned bw);
        return 32'd1 << bw;
    endfunction

endpackage

// File: rtl/umul_seq_ctrl_cntwithen.sv
// Window cycle counter with enable and synchronous clear; flags the all-ones count.
module umul_seq_ctrl_cntwithen #(
    parameter int unsigned WIDTH = 8
) (
    input  logic iClk,
    input  logic iRstN,
    input  logic iEn,
    input  logic iClr,
    output logic oFull
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Clear has priority; the count wraps to zero naturally after all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (iClr) begin
            cnt_d = '0;
        end else if (iEn) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oFull = &cnt_q;

endmodule

// File: rtl/umul_seq_ctrl.sv
// Sequences one uMUL over a full 2^BITWIDTH window: clears the RNGs, steps them
// with temporal coding, counts product ones and hands the count back via valid/ready.
module umul_seq_ctrl
    import umul_seq_ctrl_pkg::*;
#(
    parameter int unsigned BITWIDTH = BITWIDTH_DEF
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iValid,
    output logic                oReady,
    input  logic [BITWIDTH-1:0] iOpA,
    input  logic [BITWIDTH-1:0] iOpB,
    input  logic                iAbort,
    input  logic [BITWIDTH-1:0] iRandA,
    input  logic [BITWIDTH-1:0] iRandB,
    output logic                oRngEnA,
    output logic                oRngEnB,
    output logic                oRngClr,
    output logic                oValid,
    input  logic                iReady,
    output logic [BITWIDTH-1:0] oProd,
    output logic                oBusy
);

    localparam int unsigned WIN_LEN = win_len(BITWIDTH);
    localparam int unsigned CNT_W   = $clog2(WIN_LEN);

    state_e              state_q, state_d;
    logic [BITWIDTH-1:0] opa_q, opa_d;
    logic [BITWIDTH-1:0] opb_q, opb_d;
    logic [BITWIDTH-1:0] acc_q, acc_d;
    logic [BITWIDTH-1:0] prod_q, prod_d;
    logic                a_bit;
    logic                b_bit;
    logic                cnt_en;
    logic                cnt_clr;
    logic                cnt_last;

    assign a_bit = (opa_q > iRandA);
    assign b_bit = (opb_q > iRandB);

    umul_seq_ctrl_cntwithen #(
        .WIDTH (CNT_W)
    ) u_cntwithen (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iEn   (cnt_en),
        .iClr  (cnt_clr),
        .oFull (cnt_last)
    );

    // Next state, operand capture, accumulation and result capture.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iValid) begin
                    opa_d   = iOpA;
                    opb_d   = iOpB;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                acc_d   = '0;
                cnt_clr = 1'b1;
                state_d = iAbort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (iAbort) begin
                    acc_d   = '0;
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                    acc_d  = acc_q + BITWIDTH'(a_bit & b_bit);
                    if (cnt_last) begin
                        prod_d  = acc_d;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (iReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    // Enables drop in the abort cycle so the RNGs stop stepping at once.
    assign oReady  = (state_q == ST_IDLE);
    assign oRngClr = (state_q == ST_CLEAR);
    assign oValid  = (state_q == ST_DONE);
    assign oBusy   = (state_q == ST_CLEAR) || (state_q == ST_RUN);
    assign oRngEnA = (state_q == ST_RUN) && !iAbort;
    assign oRngEnB = (state_q == ST_RUN) && !iAbort && a_bit;
    assign oProd   = prod_q;

endmodule
